// File: rtl/slice_ram_arbiter.sv
// slice_ram_arbiter: shares one synchronous single-port RAM between a slice
// writer and a slice reader. It counts the complete slices held in RAM,
// blocks writes when the RAM is full and reads when it is empty, and raises
// a sticky stream_ready flag once enough slices are buffered for display.
// Optional macro SLICE_RAM_ARBITER_ROUND_ROBIN_EN: alternate grants when both
// sides are eligible. When it is undefined, the writer always wins.
//
// state | meaning
// IDLE  | no RAM access this cycle
// WRITE | RAM write issued (ram_we=1), wr_ack high
// READ  | RAM read issued (ram_we=0), rd_ack high
module slice_ram_arbiter #(
  parameter int RAM_ADDR_WIDTH   = 32,
  parameter int RAM_DATA_WIDTH   = 16,
  parameter int IMAGE_IN_RAM     = 18,
  parameter int STREAM_THRESHOLD = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              wr_req,
  input  logic [RAM_ADDR_WIDTH-1:0]         wr_addr,
  input  logic [RAM_DATA_WIDTH-1:0]         wr_data,
  output logic                              wr_ack,
  input  logic                              wr_slice_done,
  input  logic                              rd_req,
  input  logic [RAM_ADDR_WIDTH-1:0]         rd_addr,
  output logic                              rd_ack,
  output logic [RAM_DATA_WIDTH-1:0]         rd_data,
  output logic                              rd_valid,
  input  logic                              rd_slice_done,
  input  logic                              flush,
  output logic [RAM_ADDR_WIDTH-1:0]         ram_addr,
  output logic [RAM_DATA_WIDTH-1:0]         ram_wdata,
  output logic                              ram_we,
  input  logic [RAM_DATA_WIDTH-1:0]         ram_rdata,
  output logic [$clog2(IMAGE_IN_RAM+1)-1:0] slice_count,
  output logic                              stream_ready
);

  localparam int               CNT_W   = $clog2(IMAGE_IN_RAM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IMAGE_IN_RAM);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] READ  = 2'd2;

  logic [1:0]                r_state;
  logic [1:0]                w_next_state;
  logic [RAM_ADDR_WIDTH-1:0] r_ram_addr;
  logic [RAM_DATA_WIDTH-1:0] r_ram_wdata;
  logic                      r_rd_valid;
  logic [CNT_W-1:0]          r_slice_count;
  logic                      r_stream_ready;

  logic w_wr_elig;
  logic w_rd_elig;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_do_wr;
  logic w_do_rd;
  logic w_thresh_met;

  // A full RAM cannot accept another slice; an empty one has nothing to read.
  assign w_wr_elig = wr_req && (r_slice_count != CNT_MAX);
  assign w_rd_elig = rd_req && (r_slice_count != '0);

`ifdef SLICE_RAM_ARBITER_ROUND_ROBIN_EN
  logic r_last_wr;

  // Remember who was served last so a conflict goes to the other side;
  // starting as "read" lets the writer win the first conflict after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last_wr <= 1'b0;
    else if (w_do_wr || w_do_rd)
      r_last_wr <= w_do_wr;
  end

  assign w_grant_wr = w_wr_elig && !(w_rd_elig && r_last_wr);
`else
  assign w_grant_wr = w_wr_elig;
`endif

  assign w_grant_rd = w_rd_elig && !w_grant_wr;

  // flush wins over any request in the same cycle, so no access is issued.
  assign w_do_wr = w_grant_wr && !flush;
  assign w_do_rd = w_grant_rd && !flush;

  // Next state is decided fresh every cycle, which allows back-to-back grants.
  always_comb begin
    w_next_state = IDLE;
    if (w_do_wr)
      w_next_state = WRITE;
    else if (w_do_rd)
      w_next_state = READ;
  end

  // FSM state plus registered RAM address/data; address holds while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_do_wr) begin
        r_ram_addr  <= wr_addr;
        r_ram_wdata <= wr_data;
      end else if (w_do_rd) begin
        r_ram_addr  <= rd_addr;
      end
    end
  end

  // RAM returns data one cycle after a read is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rd_valid <= 1'b0;
    else
      r_rd_valid <= (r_state == READ);
  end

  // Slice occupancy: saturating up/down counter; simultaneous pulses cancel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_slice_count <= '0;
    else if (flush)
      r_slice_count <= '0;
    else if (wr_slice_done && !rd_slice_done && (r_slice_count != CNT_MAX))
      r_slice_count <= r_slice_count + 1'b1;
    else if (rd_slice_done && !wr_slice_done && (r_slice_count != '0))
      r_slice_count <= r_slice_count - 1'b1;
  end

  assign w_thresh_met = (int'(r_slice_count) >= STREAM_THRESHOLD);

  // Sticky stream-start flag; once display starts it is not paused by underrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_stream_ready <= 1'b0;
    else if (flush)
      r_stream_ready <= 1'b0;
    else if (w_thresh_met)
      r_stream_ready <= 1'b1;
  end

  assign wr_ack       = (r_state == WRITE);
  assign rd_ack       = (r_state == READ);
  assign ram_we       = (r_state == WRITE);
  assign ram_addr     = r_ram_addr;
  assign ram_wdata    = r_ram_wdata;
  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_valid ? ram_rdata : '0;
  assign slice_count  = r_slice_count;
  assign stream_ready = r_stream_ready;

endmodule

// File: tb/tb_slice_ram_arbiter.sv
// Bench for slice_ram_arbiter: directed scenarios followed by random traffic,
// all compared against a cycle-level behavioural model of the arbiter.
module tb_slice_ram_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 16;
  localparam int CAP = 18;
  localparam int TH  = 1;
  localparam int CW  = $clog2(CAP + 1);

`ifdef SLICE_RAM_ARBITER_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic          wr_slice_done = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_slice_done = 1'b0;
  logic          flush = 1'b0;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;
  logic [CW-1:0] slice_count;
  logic          stream_ready;

  slice_ram_arbiter #(
    .RAM_ADDR_WIDTH(AW), .RAM_DATA_WIDTH(DW),
    .IMAGE_IN_RAM(CAP), .STREAM_THRESHOLD(TH)
  ) dut (
    .clk(clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .wr_slice_done(wr_slice_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_slice_done(rd_slice_done),
    .flush(flush),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .ram_rdata(ram_rdata),
    .slice_count(slice_count), .stream_ready(stream_ready)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM seen by the DUT (64 words, cleared on reset).
  logic [DW-1:0] ram_mem [64];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) ram_mem[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_we) begin
      ram_mem[ram_addr[5:0]] <= ram_wdata;
    end else begin
      ram_rdata <= ram_mem[ram_addr[5:0]];
    end
  end

  int total = 0;
  int bad   = 0;

  // Reference model state: which access the arbiter performs this cycle
  // (0 none, 1 write, 2 read), slice bookkeeping and a shadow of RAM contents.
  int            m_grant;
  bit            m_last_w;
  int            m_cnt;
  bit            m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_pend;
  logic [DW-1:0] m_mem [64];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = 0; m_last_w = 1'b0; m_cnt = 0; m_ready = 1'b0;
    m_addr = '0; m_wdata = '0; m_pend = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
  endtask

  task automatic chk_all_zero(input string ph);
    chk({ph, ".wr_ack"}, wr_ack, 0);
    chk({ph, ".rd_ack"}, rd_ack, 0);
    chk({ph, ".ram_we"}, ram_we, 0);
    chk({ph, ".ram_addr"}, ram_addr, 0);
    chk({ph, ".ram_wdata"}, ram_wdata, 0);
    chk({ph, ".rd_valid"}, rd_valid, 0);
    chk({ph, ".rd_data"}, rd_data, 0);
    chk({ph, ".slice_count"}, slice_count, 0);
    chk({ph, ".stream_ready"}, stream_ready, 0);
  endtask

  // One clock: predict from the current inputs, advance, then compare.
  task automatic step(input string ph);
    int g;
    bit we_ok, re_ok, exp_vld;
    logic [DW-1:0] exp_data;
    we_ok = wr_req && (m_cnt != CAP);
    re_ok = rd_req && (m_cnt != 0);
    if (flush) g = 0;
    else if (we_ok && re_ok) g = (RR && m_last_w) ? 2 : 1;
    else if (we_ok) g = 1;
    else if (re_ok) g = 2;
    else g = 0;

    exp_vld  = (m_grant == 2);
    exp_data = m_pend;
    if (g == 1) begin
      m_addr = wr_addr; m_wdata = wr_data; m_mem[wr_addr[5:0]] = wr_data;
    end else if (g == 2) begin
      m_addr = rd_addr; m_pend = m_mem[rd_addr[5:0]];
    end
    if (g != 0) m_last_w = (g == 1);
    m_grant = g;

    if (!flush && m_cnt >= TH) m_ready = 1'b1;
    if (flush) begin
      m_cnt = 0; m_ready = 1'b0;
    end else if (wr_slice_done && !rd_slice_done) begin
      if (m_cnt < CAP) m_cnt++;
    end else if (rd_slice_done && !wr_slice_done) begin
      if (m_cnt > 0) m_cnt--;
    end

    @(posedge clk);
    #1;
    chk({ph, ".wr_ack"}, wr_ack, (g == 1));
    chk({ph, ".rd_ack"}, rd_ack, (g == 2));
    chk({ph, ".ram_we"}, ram_we, (g == 1));
    chk({ph, ".ram_addr"}, ram_addr, m_addr);
    if (g == 1) chk({ph, ".ram_wdata"}, ram_wdata, m_wdata);
    chk({ph, ".rd_valid"}, rd_valid, exp_vld);
    if (exp_vld) chk({ph, ".rd_data"}, rd_data, exp_data);
    chk({ph, ".slice_count"}, slice_count, m_cnt);
    chk({ph, ".stream_ready"}, stream_ready, m_ready);
  endtask

  task automatic idle_inputs();
    wr_req = 1'b0; rd_req = 1'b0; wr_slice_done = 1'b0;
    rd_slice_done = 1'b0; flush = 1'b0;
  endtask

  initial begin
    string got;
    string want;
    model_reset();

    // Reset values
    #12;
    chk_all_zero("reset");
    rst = 1'b0;

    // Single write: addr 5, data ABCD
    wr_req = 1'b1; wr_addr = 5; wr_data = 16'hABCD;
    step("wr_only");
    chk("wr_only.addr5", ram_addr, 5);
    chk("wr_only.data", ram_wdata, 16'hABCD);
    wr_req = 1'b0;
    step("wr_only_done");

    // Read latency: store 1234 at addr 7, buffer one slice, then read it
    wr_req = 1'b1; wr_addr = 7; wr_data = 16'h1234;
    step("rd_lat_prep");
    wr_req = 1'b0; wr_slice_done = 1'b1;
    step("rd_lat_slice");
    wr_slice_done = 1'b0;
    rd_req = 1'b1; rd_addr = 7;
    step("rd_lat_req");
    chk("rd_lat.ack", rd_ack, 1);
    rd_req = 1'b0;
    step("rd_lat_data");
    chk("rd_lat.valid", rd_valid, 1);
    chk("rd_lat.data", rd_data, 16'h1234);
    step("rd_lat_after");

    // Conflict: both eligible for four cycles
    got = "";
    want = RR ? "WRWR" : "WWWW";
    wr_req = 1'b1; rd_req = 1'b1; wr_addr = 9; rd_addr = 7; wr_data = 16'h0F0F;
    for (int i = 0; i < 4; i++) begin
      step("conflict");
      got = {got, wr_ack ? "W" : (rd_ack ? "R" : "-")};
    end
    total++;
    assert (got == want)
    else begin
      bad++;
      $error("FAIL conflict_order observed=%s expected=%s", got, want);
    end
    idle_inputs();
    step("conflict_done");

    // Occupancy: fill to capacity, writes blocked, one read slice frees room
    flush = 1'b1;
    step("occ_flush");
    flush = 1'b0;
    for (int i = 0; i < CAP + 1; i++) begin
      wr_slice_done = 1'b1;
      step("occ_fill");
    end
    wr_slice_done = 1'b0;
    chk("occ.full", slice_count, 18);
    wr_req = 1'b1; wr_addr = 11; wr_data = 16'h5555;
    for (int i = 0; i < 3; i++) begin
      step("occ_blocked");
      chk("occ.no_ack", wr_ack, 0);
    end
    rd_slice_done = 1'b1;
    step("occ_free");
    rd_slice_done = 1'b0;
    chk("occ.17", slice_count, 17);
    step("occ_wr_again");
    chk("occ.ack_again", wr_ack, 1);
    wr_req = 1'b0;
    wr_slice_done = 1'b1; rd_slice_done = 1'b1;
    step("occ_both");
    chk("occ.both_hold", slice_count, 17);
    idle_inputs();

    // Stream start, sticky through drain, cleared by flush
    flush = 1'b1; wr_req = 1'b1; rd_req = 1'b1; wr_slice_done = 1'b1;
    step("stream_flush");
    chk("stream.flush_cnt", slice_count, 0);
    chk("stream.flush_noack", wr_ack | rd_ack, 0);
    idle_inputs();
    wr_slice_done = 1'b1;
    step("stream_one");
    wr_slice_done = 1'b0;
    chk("stream.not_yet", stream_ready, 0);
    step("stream_set");
    chk("stream.set", stream_ready, 1);
    rd_slice_done = 1'b1;
    step("stream_drain");
    rd_slice_done = 1'b0;
    step("stream_sticky");
    chk("stream.sticky", stream_ready, 1);
    flush = 1'b1;
    step("stream_clear");
    flush = 1'b0;
    chk("stream.cleared", stream_ready, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      wr_req        = ($urandom_range(1, 0) == 1);
      rd_req        = ($urandom_range(1, 0) == 1);
      wr_addr       = AW'($urandom_range(63, 0));
      rd_addr       = AW'($urandom_range(63, 0));
      wr_data       = DW'($urandom);
      wr_slice_done = ($urandom_range(3, 0) == 0);
      rd_slice_done = ($urandom_range(3, 0) == 0);
      flush         = ($urandom_range(39, 0) == 0);
      step("rand");
    end
    idle_inputs();
    step("rand_done");

    // Reset in the middle of a granted read
    wr_slice_done = 1'b1;
    step("rst_prep");
    wr_slice_done = 1'b0;
    rd_req = 1'b1; rd_addr = 3;
    step("rst_rd");
    chk("rst_rd.ack", rd_ack, 1);
    rd_req = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk_all_zero("rst_async");
    @(posedge clk);
    #1;
    chk_all_zero("rst_held");
    #2;
    rst = 1'b0;
    step("rst_after1");
    chk("rst_after.no_valid", rd_valid, 0);
    step("rst_after2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/slice_ram_arbiter.md
SLICE_RAM_ARBITER -- requirements
Module: slice_ram_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning): RAM_ADDR_WIDTH, 32, RAM address width; RAM_DATA_WIDTH, 16, RAM word width; IMAGE_IN_RAM, 18, slice capacity of RAM; STREAM_THRESHOLD, 1, complete slices required before display starts.
REQ-002 SHALL have ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- wr_req  in  1  writer requests one RAM write; held until wr_ack.
- wr_addr  in  RAM_ADDR_WIDTH  write address.
- wr_data  in  RAM_DATA_WIDTH  write data.
- wr_ack  out  1  one-cycle pulse: write issued.
- wr_slice_done  in  1  pulse: writer finished one complete slice.
- rd_req  in  1  reader requests one RAM read; held until rd_ack.
- rd_addr  in  RAM_ADDR_WIDTH  read address.
- rd_ack  out  1  one-cycle pulse: read issued.
- rd_data  out  RAM_DATA_WIDTH  read data.
- rd_valid  out  1  rd_data valid.
- rd_slice_done  in  1  pulse: reader finished one slice.
- flush  in  1  synchronous clear of slice bookkeeping.
- ram_addr  out  RAM_ADDR_WIDTH  registered RAM address.
- ram_wdata  out  RAM_DATA_WIDTH  registered RAM write data.
- ram_we  out  1  registered RAM write enable.
- ram_rdata  in  RAM_DATA_WIDTH  synchronous-read RAM data, one cycle after address.
- slice_count  out  $clog2(IMAGE_IN_RAM+1)  complete unread slices in RAM.
- stream_ready  out  1  enough slices buffered for display.

Function
REQ-003 SHALL issue at most one RAM access per cycle.
REQ-004 SHALL be a three-state FSM: IDLE (no access), WRITE (ram_we=1, ram_addr/ram_wdata from wr_addr/wr_data), READ (ram_we=0, ram_addr=rd_addr); next state decided each cycle from the requests eligible in that cycle.
REQ-005 Write eligible SHALL be wr_req && slice_count != IMAGE_IN_RAM; read eligible SHALL be rd_req && slice_count != 0.
REQ-006 Eligible request sampled at edge N SHALL drive RAM outputs and the matching ack during cycle N+1; consecutive grants to the same requester SHALL be allowed (one access per cycle sustained).
REQ-007 rd_valid SHALL be high, and rd_data SHALL equal ram_rdata, in cycle N+2 for a read granted at N+1; rd_valid low otherwise.
REQ-008 With no eligible request the FSM SHALL go to IDLE with ram_we=0 and ram_addr holding its last value.
REQ-009 slice_count SHALL increment on wr_slice_done, decrement on rd_slice_done, and stay unchanged when both pulse in the same cycle.
REQ-010 slice_count SHALL saturate: wr_slice_done alone at IMAGE_IN_RAM and rd_slice_done alone at 0 SHALL be ignored.
REQ-011 stream_ready SHALL set the cycle after slice_count >= STREAM_THRESHOLD and SHALL stay set (sticky) until rst or flush.
REQ-012 flush SHALL, next edge, clear slice_count and stream_ready and force IDLE; flush SHALL override simultaneous slice pulses and requests in that cycle (no ack issued).

Reset
REQ-013 On rst, asynchronously: state IDLE, ram_we=0, ram_addr=0, ram_wdata=0, wr_ack=0, rd_ack=0, rd_valid=0, rd_data=0, slice_count=0, stream_ready=0.
REQ-014 rst asserted mid-access SHALL abort it; no ack or rd_valid for the aborted access after rst deassert.

Configuration
REQ-015 With macro SLICE_RAM_ARBITER_ROUND_ROBIN_EN defined, when both are eligible the grant SHALL go to the requester not granted last (write first after reset).
REQ-016 Without it, when both are eligible write SHALL always win (reader may starve).

Verification
REQ-017 Write only: wr_req=1, wr_addr=5, wr_data=16'hABCD at edge 0 -> cycle 1 ram_we=1, ram_addr=5, ram_wdata=16'hABCD, wr_ack=1.
REQ-018 Read latency: slice_count=1, rd_req with rd_addr=7 at edge 0, RAM returns 16'h1234 -> rd_ack cycle 1, rd_valid=1 with rd_data=16'h1234 cycle 2.
REQ-019 Conflict: both eligible 4 consecutive cycles -> round-robin build grants W,R,W,R; fixed build grants W,W,W,W.
REQ-020 Occupancy: 18 wr_slice_done pulses -> slice_count=18, further wr_req never acked; one rd_slice_done -> 17, writes acked again; simultaneous pulses leave count unchanged.
REQ-021 Stream start: STREAM_THRESHOLD=1, one wr_slice_done -> stream_ready=1 one cycle after slice_count becomes 1; rd_slice_done back to 0 -> stream_ready stays 1; flush -> slice_count=0, stream_ready=0 next cycle.
REQ-022 Reset mid-read: rst during cycle 1 of a granted read -> all outputs 0 immediately, no rd_valid after deassert.
